// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard/trap controller: stage control word, trap payload, cause codes.
package hazard_scoreboard_pkg;

    typedef struct packed {
        logic stall;
        logic flush;
    } control;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC  = 2'd2
    } writebackType_;

    typedef enum logic [3:0] {
        TRAP_NONE         = 4'd0,
        TRAP_ILLEGAL      = 4'd1,
        TRAP_MIS_STORE    = 4'd2,
        TRAP_MIS_LOAD     = 4'd3,
        TRAP_MIS_INST     = 4'd4,
        TRAP_ECALL        = 4'd5,
        TRAP_EBREAK       = 4'd6,
        TRAP_ACCESS_STORE = 4'd7,
        TRAP_ACCESS_LOAD  = 4'd8,
        TRAP_ACCESS_INST  = 4'd9
    } trapType_;

    typedef struct packed {
        trapType_    trapType;
        logic [31:0] faultingAddress;
    } trapPayload_;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam int TRAP_PAYLOAD_W = $bits(trapPayload_);
    localparam int CONTROL_W      = $bits(control);

    localparam logic [3:0] MCAUSE_MIS_INST     = 4'd0;
    localparam logic [3:0] MCAUSE_ACCESS_INST  = 4'd1;
    localparam logic [3:0] MCAUSE_ILLEGAL      = 4'd2;
    localparam logic [3:0] MCAUSE_EBREAK       = 4'd3;
    localparam logic [3:0] MCAUSE_MIS_LOAD     = 4'd4;
    localparam logic [3:0] MCAUSE_ACCESS_LOAD  = 4'd5;
    localparam logic [3:0] MCAUSE_MIS_STORE    = 4'd6;
    localparam logic [3:0] MCAUSE_ACCESS_STORE = 4'd7;
    localparam logic [3:0] MCAUSE_ECALL        = 4'd11;

    function automatic logic [3:0] trap_cause(input trapType_ t);
        case (t)
            TRAP_ILLEGAL:      trap_cause = MCAUSE_ILLEGAL;
            TRAP_MIS_STORE:    trap_cause = MCAUSE_MIS_STORE;
            TRAP_MIS_LOAD:     trap_cause = MCAUSE_MIS_LOAD;
            TRAP_MIS_INST:     trap_cause = MCAUSE_MIS_INST;
            TRAP_ECALL:        trap_cause = MCAUSE_ECALL;
            TRAP_EBREAK:       trap_cause = MCAUSE_EBREAK;
            TRAP_ACCESS_STORE: trap_cause = MCAUSE_ACCESS_STORE;
            TRAP_ACCESS_LOAD:  trap_cause = MCAUSE_ACCESS_LOAD;
            TRAP_ACCESS_INST:  trap_cause = MCAUSE_ACCESS_INST;
            default:           trap_cause = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_scoreboard_load_scoreboard.sv
// Pending-write bit per architectural register (x0 never pending) with lookup ports.
// Set beats clear for the same register; clear-all beats both.
module load_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_READ_PORTS = 2
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_setValid,
    input  logic [4:0]                  i_setDest,
    input  logic                        i_clearValid,
    input  logic [4:0]                  i_clearDest,
    input  logic                        i_clearAll,
    input  logic [NUM_READ_PORTS*5-1:0] i_lookupAddr,
    output logic [NUM_READ_PORTS-1:0]   o_lookupPending
);

    logic [31:0] r_pending;
    logic [31:0] w_nextPending;

    always_comb begin
        w_nextPending = r_pending;
        if (i_clearValid) w_nextPending[i_clearDest] = 1'b0;
        if (i_setValid)   w_nextPending[i_setDest]   = 1'b1;
        w_nextPending[0] = 1'b0;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clearAll) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_nextPending;
        end
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_lookup
        assign o_lookupPending[p] = r_pending[i_lookupAddr[p*5 +: 5]];
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard/trap controller: load-use stalls via issue compare and pending scoreboard,
// front-end redirect flushes, and a trap-drain FSM holding every stage flushed.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_STAGES      = 4,
    parameter int NUM_READ_PORTS  = 2,
    parameter int FRONT_FLUSH     = 2,
    parameter int DRAIN_CYCLES    = 2,
    parameter int BYPASS_COMPLETE = 1
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_decodeValid,
    input  logic                           i_decodeIllegal,
    input  logic [NUM_READ_PORTS*5-1:0]    i_readAddress,
    input  logic                           i_issueValid,
    input  logic                           i_issueWritesMem,
    input  logic [4:0]                     i_issueDest,
    input  logic                           i_completeValid,
    input  logic [4:0]                     i_completeDest,
    input  logic                           i_branchValid,
    input  logic                           i_mretSignal,
    input  logic                           i_stallControl,
    input  logic                           i_trapValid,
    input  logic [TRAP_PAYLOAD_W-1:0]      i_trapData,
    output logic [NUM_STAGES*CONTROL_W-1:0] o_stageControl,
    output logic                           o_controlReset,
    output logic [3:0]                     o_mcause,
    output logic [31:0]                    o_mtval,
    output logic                           o_trapBusy
);

    localparam int CW        = $clog2(DRAIN_CYCLES + 1);
    localparam int ISSUE_IDX = (NUM_STAGES > 1) ? 1 : 0;

    state_t                     r_state;
    state_t                     w_nextState;
    state_t                     w_state;
    logic [CW-1:0]              r_count;
    logic [3:0]                 r_mcause;
    logic [31:0]                r_mtval;
    trapPayload_                w_trap;
    logic                       w_trapAccept;
    logic                       w_inDrain;
    logic                       w_setPending;
    logic [NUM_READ_PORTS-1:0]  w_lookupPending;
    logic [NUM_READ_PORTS-1:0]  w_portHazard;
    logic                       w_loadUse;
    control [NUM_STAGES-1:0]    w_ctl;

    // Reset forces the effective state to IDLE so outputs show reset values immediately.
    assign w_state      = i_reset ? ST_IDLE : r_state;
    assign w_trap       = trapPayload_'(i_trapData);
    assign w_trapAccept = !i_reset && (w_state == ST_IDLE) && i_trapValid;
    assign w_inDrain    = (w_state == ST_DRAIN);
    assign w_setPending = i_issueValid && i_issueWritesMem && !i_stallControl && (w_state == ST_IDLE);

    load_scoreboard #(
        .NUM_READ_PORTS (NUM_READ_PORTS)
    ) u_load_scoreboard (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_setValid      (w_setPending),
        .i_setDest       (i_issueDest),
        .i_clearValid    (i_completeValid),
        .i_clearDest     (i_completeDest),
        .i_clearAll      (w_trapAccept || w_inDrain),
        .i_lookupAddr    (i_readAddress),
        .o_lookupPending (w_lookupPending)
    );

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
        logic [4:0] w_ra;
        logic       w_issueHit;
        logic       w_pendHit;
        assign w_ra       = i_readAddress[p*5 +: 5];
        assign w_issueHit = i_issueValid && i_issueWritesMem && (i_issueDest == w_ra);
        assign w_pendHit  = w_lookupPending[p] && !i_reset &&
                            !((BYPASS_COMPLETE != 0) && i_completeValid && (i_completeDest == w_ra));
        assign w_portHazard[p] = i_decodeValid && !i_decodeIllegal && (w_ra != 5'd0) &&
                                 (w_issueHit || w_pendHit);
    end

    assign w_loadUse = (|w_portHazard) && !i_stallControl;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == ST_IDLE && i_trapValid) begin
                r_count <= CW'(DRAIN_CYCLES);
            end else if (r_state == ST_DRAIN && !i_stallControl) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (i_trapValid) w_nextState = ST_DRAIN;
            ST_DRAIN: if (!i_stallControl && r_count == CW'(1)) w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ctl = '0;
        for (int s = 0; s < NUM_STAGES; s++) w_ctl[s].stall = i_stallControl;
        if (w_trapAccept || w_inDrain) begin
            for (int s = 0; s < NUM_STAGES; s++) w_ctl[s].flush = 1'b1;
        end else begin
            if (i_branchValid || i_mretSignal) begin
                for (int s = 0; s < NUM_STAGES; s++) begin
                    if (s < FRONT_FLUSH) w_ctl[s].flush = 1'b1;
                end
            end
            if (w_loadUse) begin
                w_ctl[0].stall = 1'b1;
                if (NUM_STAGES > 1) w_ctl[ISSUE_IDX].flush = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_mcause <= '0;
            r_mtval  <= '0;
        end else if (w_trapAccept) begin
            r_mcause <= trap_cause(w_trap.trapType);
            r_mtval  <= w_trap.faultingAddress;
        end
    end

    assign o_stageControl = w_ctl;
    assign o_controlReset = w_trapAccept;
    assign o_trapBusy     = w_inDrain;
    assign o_mcause       = i_reset ? 4'd0 : (w_trapAccept ? trap_cause(w_trap.trapType) : r_mcause);
    assign o_mtval        = i_reset ? 32'd0 : (w_trapAccept ? w_trap.faultingAddress : r_mtval);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard-driven bench: expected outputs queued per driven cycle, popped and compared at negedge.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        decodeValid, decodeIllegal;
    logic [9:0]  readAddress;
    logic        issueValid, issueWritesMem;
    logic [4:0]  issueDest;
    logic        completeValid;
    logic [4:0]  completeDest;
    logic        branchValid, mretSignal, stallControl, trapValid;
    trapPayload_ trapData;

    logic [7:0]  sc, sc_nb;
    logic        cr, cr_nb, busy, busy_nb;
    logic [3:0]  mc, mc_nb;
    logic [31:0] mt, mt_nb;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  sc;
        logic        cr;
        logic        busy;
        logic [3:0]  mc;
        logic [31:0] mt;
        logic [7:0]  sc_nb;
    } exp_t;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    hazard_scoreboard dut (
        .i_clock(clock), .i_reset(reset),
        .i_decodeValid(decodeValid), .i_decodeIllegal(decodeIllegal),
        .i_readAddress(readAddress),
        .i_issueValid(issueValid), .i_issueWritesMem(issueWritesMem), .i_issueDest(issueDest),
        .i_completeValid(completeValid), .i_completeDest(completeDest),
        .i_branchValid(branchValid), .i_mretSignal(mretSignal),
        .i_stallControl(stallControl), .i_trapValid(trapValid), .i_trapData(trapData),
        .o_stageControl(sc), .o_controlReset(cr), .o_mcause(mc), .o_mtval(mt), .o_trapBusy(busy)
    );

    hazard_scoreboard #(.BYPASS_COMPLETE(0)) dut_nb (
        .i_clock(clock), .i_reset(reset),
        .i_decodeValid(decodeValid), .i_decodeIllegal(decodeIllegal),
        .i_readAddress(readAddress),
        .i_issueValid(issueValid), .i_issueWritesMem(issueWritesMem), .i_issueDest(issueDest),
        .i_completeValid(completeValid), .i_completeDest(completeDest),
        .i_branchValid(branchValid), .i_mretSignal(mretSignal),
        .i_stallControl(stallControl), .i_trapValid(trapValid), .i_trapData(trapData),
        .o_stageControl(sc_nb), .o_controlReset(cr_nb), .o_mcause(mc_nb), .o_mtval(mt_nb),
        .o_trapBusy(busy_nb)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic idle_inputs();
        decodeValid = 0; decodeIllegal = 0; readAddress = '0;
        issueValid = 0; issueWritesMem = 0; issueDest = '0;
        completeValid = 0; completeDest = '0;
        branchValid = 0; mretSignal = 0; stallControl = 0; trapValid = 0;
        trapData = '{trapType: TRAP_NONE, faultingAddress: 32'h0};
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        decodeValid = 1; readAddress = {a1, a0};
    endtask

    task automatic ld(input logic [4:0] d);
        issueValid = 1; issueWritesMem = 1; issueDest = d;
    endtask

    task automatic trap(input trapType_ t, input logic [31:0] a);
        trapValid = 1; trapData = '{trapType: t, faultingAddress: a};
    endtask

    // Inputs are already driven; queue the expectation, compare at negedge, return just after posedge.
    task automatic step(input string tag, input logic [7:0] esc, input logic ecr, input logic ebusy,
                        input logic [3:0] emc, input logic [31:0] emt, input logic [8:0] esc_nb = 9'h100);
        exp_t e;
        e.sc = esc; e.cr = ecr; e.busy = ebusy; e.mc = emc; e.mt = emt;
        e.sc_nb = esc_nb[8] ? esc : esc_nb[7:0];
        exp_q.push_back(e);
        @(negedge clock);
        e = exp_q.pop_front();
        check_eq({tag, ".stageControl"}, 32'(sc), 32'(e.sc));
        check_eq({tag, ".controlReset"}, 32'(cr), 32'(e.cr));
        check_eq({tag, ".trapBusy"}, 32'(busy), 32'(e.busy));
        check_eq({tag, ".mcause"}, 32'(mc), 32'(e.mc));
        check_eq({tag, ".mtval"}, mt, e.mt);
        check_eq({tag, ".nb_stageControl"}, 32'(sc_nb), 32'(e.sc_nb));
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1;
        step("rst_idle", 8'h00, 0, 0, 4'd0, 32'h0);
        trap(TRAP_MIS_LOAD, 32'h1003);
        step("rst_trap_ignored", 8'h00, 0, 0, 4'd0, 32'h0);
        reset = 0; idle_inputs();

        // Load-use through issue path, then through pending
        ld(5); rd(5, 0);
        step("lu_issue", 8'h06, 0, 0, 4'd0, 32'h0);
        idle_inputs(); rd(3, 5);
        step("lu_pending", 8'h06, 0, 0, 4'd0, 32'h0);
        rd(5, 0); completeValid = 1; completeDest = 5;
        step("bypass_complete", 8'h00, 0, 0, 4'd0, 32'h0, 9'h006);
        idle_inputs(); rd(5, 0);
        step("after_clear", 8'h00, 0, 0, 4'd0, 32'h0);

        idle_inputs(); ld(6); rd(6, 0); decodeIllegal = 1;
        step("illegal", 8'h00, 0, 0, 4'd0, 32'h0);
        idle_inputs(); rd(0, 6);
        step("pend6", 8'h06, 0, 0, 4'd0, 32'h0);
        idle_inputs(); completeValid = 1; completeDest = 6;
        step("clr6", 8'h00, 0, 0, 4'd0, 32'h0);

        idle_inputs(); stallControl = 1; ld(9); rd(9, 0);
        step("stall_global", 8'hAA, 0, 0, 4'd0, 32'h0);
        idle_inputs(); rd(9, 0);
        step("stall_blocks_set", 8'h00, 0, 0, 4'd0, 32'h0);

        idle_inputs(); ld(0); rd(0, 0);
        step("x0_issue", 8'h00, 0, 0, 4'd0, 32'h0);
        idle_inputs(); rd(0, 0);
        step("x0_pending", 8'h00, 0, 0, 4'd0, 32'h0);

        idle_inputs(); ld(7); completeValid = 1; completeDest = 7;
        step("x7_set_clr", 8'h00, 0, 0, 4'd0, 32'h0);
        idle_inputs(); rd(7, 0);
        step("x7_set_wins", 8'h06, 0, 0, 4'd0, 32'h0);
        completeValid = 1; completeDest = 7;
        step("x7_bypass", 8'h00, 0, 0, 4'd0, 32'h0, 9'h006);

        idle_inputs(); branchValid = 1;
        step("branch", 8'h05, 0, 0, 4'd0, 32'h0);
        idle_inputs(); mretSignal = 1;
        step("mret", 8'h05, 0, 0, 4'd0, 32'h0);
        idle_inputs(); mretSignal = 1; stallControl = 1;
        step("mret_stall", 8'hAF, 0, 0, 4'd0, 32'h0);

        // Trap with a pending load outstanding; DRAIN ignores trap/branch/hazard
        idle_inputs(); ld(12);
        step("ld12", 8'h00, 0, 0, 4'd0, 32'h0);
        idle_inputs(); trap(TRAP_MIS_LOAD, 32'h1003);
        step("trap_accept", 8'h55, 1, 0, 4'd4, 32'h1003);
        trap(TRAP_ECALL, 32'h2000); branchValid = 1; rd(12, 0);
        step("drain1", 8'h55, 0, 1, 4'd4, 32'h1003);
        trapValid = 0;
        step("drain2", 8'h55, 0, 1, 4'd4, 32'h1003);
        idle_inputs(); rd(12, 0);
        step("drain_done", 8'h00, 0, 0, 4'd4, 32'h1003);

        // Stall during DRAIN freezes the counter
        idle_inputs(); trap(TRAP_ECALL, 32'h2000);
        step("trap_ecall", 8'h55, 1, 0, 4'd11, 32'h2000);
        idle_inputs(); stallControl = 1;
        step("drain_stall", 8'hFF, 0, 1, 4'd11, 32'h2000);
        idle_inputs();
        step("drain_s1", 8'h55, 0, 1, 4'd11, 32'h2000);
        step("drain_s2", 8'h55, 0, 1, 4'd11, 32'h2000);
        step("drain_s_done", 8'h00, 0, 0, 4'd11, 32'h2000);

        // Reset in the second DRAIN cycle
        trap(TRAP_ILLEGAL, 32'h40);
        step("trap_illegal", 8'h55, 1, 0, 4'd2, 32'h40);
        idle_inputs();
        step("rd_drain1", 8'h55, 0, 1, 4'd2, 32'h40);
        reset = 1;
        step("rd_reset", 8'h00, 0, 0, 4'd0, 32'h0);
        reset = 0; rd(12, 0);
        step("rd_after", 8'h00, 0, 0, 4'd0, 32'h0);
        idle_inputs(); trap(TRAP_EBREAK, 32'h8);
        step("trap_ebreak", 8'h55, 1, 0, 4'd3, 32'h8);
        idle_inputs(); trap(TRAP_ACCESS_INST, 32'hC);
        step("drain_ignores_trap", 8'h55, 0, 1, 4'd3, 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
